cont_seq: RTL and testbench
===========================

Name: cont_seq

Overview:
Sequencer for the team's 4-bit up/down counter datapath. On a start command it loads a lower bound, sweeps the counter up to an upper bound and back down, and repeats for a programmed number of sweeps. It then pulses done. It sits between the register/command interface and the counter, and owns the counter's load, enable and direction controls.

Parameters:
W, 4, counter width in bits (lo, hi, cnt).
SW, 4, sweep-count width in bits (sweeps input and internal sweep counter).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
start  input  1  command strobe; sampled only in IDLE.
abort  input  1  stop request; effective in any state.
lo  input  W  lower bound; captured on an accepted start.
hi  input  W  upper bound; captured on an accepted start.
sweeps  input  SW  number of full sweeps; 0 means 1.
cnt  output  W  counter value (registered).
dir  output  1  0 = counting up, 1 = counting down.
busy  output  1  high in RUN_UP and RUN_DN.
done  output  1  one-cycle pulse at normal completion.
err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; cnt=0, dir=0, busy=0, done=0, err=0; sweep counter=0; captured lo/hi=0. rst overrides all other inputs.
- States: IDLE, RUN_UP, RUN_DN, DONE. Registered one-hot or binary encoding; busy/done derive from state only (no combinational input-to-output paths).
- IDLE, start=1, abort=0, lo<hi: capture lo/hi/sweeps; cnt<=lo, dir<=0, sweep counter<=0; go to RUN_UP. busy is high from the next cycle.
- IDLE, start=1, lo>=hi: stay in IDLE, err=1 for one cycle, cnt unchanged.
- IDLE, start=1 and abort=1 together: abort wins, start ignored, no err.
- RUN_UP: cnt<=cnt+1 each cycle. On the edge where cnt becomes captured hi, go to RUN_DN with dir<=1.
- RUN_DN: cnt<=cnt-1 each cycle. On the edge where cnt becomes captured lo, increment the sweep counter.
  - If the incremented count >= max(sweeps,1), go to DONE.
  - Otherwise go to RUN_UP with dir<=0.
- Sequence per sweep: lo, lo+1, …, hi, hi-1, …, lo. Sweep length is 2*(hi-lo) cycles.
- Final lo appears 2*N*(hi-lo) cycles after the start-accept edge, where N = max(sweeps,1).
- DONE: done=1, busy=0, cnt holds lo. Return to IDLE on the next edge unconditionally.
- abort in RUN_UP/RUN_DN: go to IDLE next edge. cnt freezes at its current value, dir cleared, no done pulse.
- start while busy: ignored; no err.
- lo/hi/sweeps changes while busy: ignored (captured copies used).
- Arithmetic: cnt never wraps in normal operation because it is bounded by lo..hi. Modulo-2^W wrap is the defined fallback. hi=2^W-1 must reach the top value without overflow.
- hi-lo=1: alternates lo, hi, lo each cycle; still counts sweeps correctly.

Optional Feature:
CONT_SEQ_HOLD_EN:
- Defined: adds input port hold (1 bit). While hold=1 in RUN_UP/RUN_DN, cnt, dir, state and sweep counter freeze; busy stays 1. abort still takes effect during hold. hold is ignored in IDLE/DONE.
- Not defined: no hold port; counting never pauses.

Decomposition:
- Package cont_pkg holds:
  - the state typedef (IDLE, RUN_UP, RUN_DN, DONE);
  - default width constants CNT_W=4 and SWEEP_W=4.
- Sub-module cnt_updn: W-bit up/down counter with synchronous rst, load, load value, enable and direction inputs.
- cont_seq instantiates one cnt_updn and drives its controls from the FSM.

Test Plan:
- Reset mid-run: start lo=2, hi=5, sweeps=1, then rst on cycle 3 -> next cycle cnt=0, busy=0, state IDLE, no done.
- Single sweep: lo=2, hi=5, sweeps=1 -> cnt 2,3,4,5,4,3,2; done pulses exactly once, 6 cycles after the accept edge; busy low with done.
- Multi-sweep with boundaries: lo=0, hi=15, sweeps=3 -> three 0..15..0 sweeps, 90 cycles, no wrap; done once.
- Reject: lo=7, hi=7, start -> err=1 for one cycle, busy stays 0, cnt unchanged. Repeat with lo=9, hi=3 -> same result.
- Abort and late start: abort while cnt=4 in RUN_UP -> IDLE next cycle, cnt holds 4, no done. A start pulse during busy has no effect.
- hold (CONT_SEQ_HOLD_EN defined): hold=1 for 5 cycles mid-sweep -> cnt constant, busy=1, completion delayed exactly 5 cycles.

Source files
------------

// File: rtl/cont_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cont_pkg
//  Description : Shared types and default widths for the counter sequencer
//                (cont_seq) and its up/down counter (cnt_updn).
//  Revision    : 1.0 - initial release
// ============================================================================
package cont_pkg;

    // Default counter width (lo, hi, cnt)
    localparam int CNT_W   = 4;
    // Default sweep-count width (sweeps input and internal sweep counter)
    localparam int SWEEP_W = 4;

    // Sequencer states, binary encoded
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_UP = 2'd1,
        RUN_DN = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage : cont_pkg
`default_nettype wire

// File: rtl/cnt_updn.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_updn
//  Description : W-bit up/down counter with synchronous reset, parallel load
//                and count enable. Load has priority over counting; the count
//                wraps modulo 2^W.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnt_updn
    import cont_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         dn,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // Counter register: reset, then load, then count in the requested direction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en) begin
            r_cnt <= dn ? (r_cnt - W'(1)) : (r_cnt + W'(1));
        end
    end

    assign cnt = r_cnt;

endmodule : cnt_updn
`default_nettype wire

// File: rtl/cont_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cont_seq
//  Description : Sweep sequencer for the up/down counter. On an accepted
//                start it loads lo, counts up to hi and back down to lo, and
//                repeats for max(sweeps,1) sweeps before pulsing done.
//                Optional macro CONT_SEQ_HOLD_EN adds a 'hold' input that
//                freezes a running sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module cont_seq
    import cont_pkg::*;
#(
    parameter int W  = CNT_W,
    parameter int SW = SWEEP_W
) (
    input  logic          clk,
    input  logic          rst,
`ifdef CONT_SEQ_HOLD_EN
    input  logic          hold,
`endif
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [SW-1:0] sweeps,
    output logic [W-1:0]  cnt,
    output logic          dir,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [W-1:0]  r_lo;
    logic [W-1:0]  r_hi;
    logic [SW-1:0] r_sweeps;
    logic [SW-1:0] r_sweep_cnt;
    logic          r_dir;
    logic          r_err;

    logic          w_hold;
    logic          w_load;
    logic          w_en;
    logic          w_dn;
    logic          w_capture;
    logic          w_dir_nxt;
    logic          w_err_nxt;
    logic [SW-1:0] w_sweep_nxt;
    logic [W-1:0]  w_cnt;
    logic [W-1:0]  w_cnt_up;
    logic [W-1:0]  w_cnt_dn;
    logic [SW:0]   w_sweep_inc;
    logic [SW:0]   w_sweep_tgt;

`ifdef CONT_SEQ_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    // Counter datapath; the FSM owns its load, enable and direction controls
    cnt_updn #(
        .W        (W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (lo),
        .en       (w_en),
        .dn       (w_dn),
        .cnt      (w_cnt)
    );

    // Look-ahead values: the FSM turns around on the edge the counter reaches a bound
    assign w_cnt_up    = w_cnt + W'(1);
    assign w_cnt_dn    = w_cnt - W'(1);
    // One extra bit so the incremented sweep count never aliases the target
    assign w_sweep_inc = {1'b0, r_sweep_cnt} + (SW+1)'(1);
    assign w_sweep_tgt = (r_sweeps == '0) ? (SW+1)'(1) : {1'b0, r_sweeps};

    // Next-state and counter-control decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_en        = 1'b0;
        w_dn        = 1'b0;
        w_capture   = 1'b0;
        w_dir_nxt   = r_dir;
        w_err_nxt   = 1'b0;
        w_sweep_nxt = r_sweep_cnt;
        case (r_state)
            IDLE: begin
                // abort outranks start; a bad range is reported, not run
                if (start && !abort) begin
                    if (lo < hi) begin
                        w_capture   = 1'b1;
                        w_load      = 1'b1;
                        w_dir_nxt   = 1'b0;
                        w_sweep_nxt = '0;
                        w_state_nxt = RUN_UP;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            RUN_UP: begin
                if (abort) begin
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else if (!w_hold) begin
                    w_en = 1'b1;
                    if (w_cnt_up == r_hi) begin
                        w_dir_nxt   = 1'b1;
                        w_state_nxt = RUN_DN;
                    end
                end
            end
            RUN_DN: begin
                if (abort) begin
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else if (!w_hold) begin
                    w_en = 1'b1;
                    w_dn = 1'b1;
                    if (w_cnt_dn == r_lo) begin
                        w_sweep_nxt = w_sweep_inc[SW-1:0];
                        if (w_sweep_inc >= w_sweep_tgt) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_dir_nxt   = 1'b0;
                            w_state_nxt = RUN_UP;
                        end
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Captured bounds, sweep counter, direction and reject pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo        <= '0;
            r_hi        <= '0;
            r_sweeps    <= '0;
            r_sweep_cnt <= '0;
            r_dir       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_capture) begin
                r_lo     <= lo;
                r_hi     <= hi;
                r_sweeps <= sweeps;
            end
            r_sweep_cnt <= w_sweep_nxt;
            r_dir       <= w_dir_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign cnt  = w_cnt;
    assign dir  = r_dir;
    assign err  = r_err;
    assign busy = (r_state == RUN_UP) || (r_state == RUN_DN);
    assign done = (r_state == DONE);

endmodule : cont_seq
`default_nettype wire

// File: tb/tb_cont_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cont_seq
//  Description : Self-checking bench for cont_seq. A queue-based model of the
//                expected count sequence is compared against the DUT every
//                cycle; directed tests add literal timing/value expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cont_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] lo = '0;
    logic [3:0] hi = '0;
    logic [3:0] sweeps = '0;
    logic [3:0] cnt;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model state
    logic [3:0] m_cnt  = '0;
    logic       m_dir  = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err  = 1'b0;
    int         m_q[$];

    always #5 clk = ~clk;

    cont_seq dut (
        .clk    (clk),
        .rst    (rst),
`ifdef CONT_SEQ_HOLD_EN
        .hold   (hold),
`endif
        .start  (start),
        .abort  (abort),
        .lo     (lo),
        .hi     (hi),
        .sweeps (sweeps),
        .cnt    (cnt),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the run is the list of counter values still to be visited
    always @(posedge clk) begin
        bit was_done;
        int n;
        if (rst) begin
            m_cnt = '0; m_dir = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_q.delete();
        end else begin
            was_done = m_done;
            m_done   = 1'b0;
            m_err    = 1'b0;
            if (m_busy) begin
                if (abort) begin
                    m_busy = 1'b0;
                    m_dir  = 1'b0;
                    m_q.delete();
                end else if (!hold) begin
                    m_cnt = 4'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end else begin
                        m_dir = (m_q[0] < int'(m_cnt));
                    end
                end
            end else if (!was_done && start && !abort) begin
                if (lo < hi) begin
                    n = (sweeps == 0) ? 1 : int'(sweeps);
                    for (int s = 0; s < n; s++) begin
                        for (int v = int'(lo) + 1; v <= int'(hi); v++) m_q.push_back(v);
                        for (int v = int'(hi) - 1; v >= int'(lo); v--) m_q.push_back(v);
                    end
                    m_cnt  = lo;
                    m_dir  = 1'b0;
                    m_busy = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("cnt", int'(cnt), int'(m_cnt));
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(m_done));
            chk("err", int'(err), int'(m_err));
            if (m_busy) chk("dir", int'(dir), int'(m_dir));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a start; returns with the DUT one cycle past the accept edge
    task automatic go(input logic [3:0] l, input logic [3:0] h, input logic [3:0] s);
        lo = l; hi = h; sweeps = s; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        tick(); tick();
        rst = 1'b0;
        check_en = 1'b1;
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        // Reset in the middle of a run
        go(4'd2, 4'd5, 4'd1);
        chk("accept_cnt", int'(cnt), 2);
        chk("accept_busy", int'(busy), 1);
        tick(); tick();
        chk("midrun_cnt", int'(cnt), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_cnt", int'(cnt), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        tick();

        // Single sweep
        go(4'd2, 4'd5, 4'd1);
        wait_done(50, n);
        chk("single_latency", n, 6);
        chk("single_final_cnt", int'(cnt), 2);
        chk("single_busy_at_done", int'(busy), 0);
        tick();
        chk("single_done_pulse", int'(done), 0);

        // Full-range multi-sweep
        go(4'd0, 4'd15, 4'd3);
        wait_done(200, n);
        chk("multi_latency", n, 90);
        chk("multi_final_cnt", int'(cnt), 0);
        tick();

        // Rejected starts
        go(4'd7, 4'd7, 4'd1);
        chk("rej1_err", int'(err), 1);
        chk("rej1_busy", int'(busy), 0);
        chk("rej1_cnt", int'(cnt), 0);
        tick();
        chk("rej1_err_pulse", int'(err), 0);
        go(4'd9, 4'd3, 4'd1);
        chk("rej2_err", int'(err), 1);
        chk("rej2_busy", int'(busy), 0);
        tick();

        // start and abort together in IDLE
        abort = 1'b1;
        go(4'd1, 4'd3, 4'd1);
        abort = 1'b0;
        chk("startabort_busy", int'(busy), 0);
        chk("startabort_err", int'(err), 0);
        tick();

        // Abort at cnt=4 with an ignored start and input changes while busy
        go(4'd1, 4'd8, 4'd2);
        lo = 4'd0; hi = 4'd15; sweeps = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("pre_abort_cnt", int'(cnt), 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_cnt", int'(cnt), 4);
        chk("abort_dir", int'(dir), 0);
        chk("abort_done", int'(done), 0);
        repeat (4) tick();

        // Adjacent bounds, sweeps=0 counts as one
        go(4'd3, 4'd4, 4'd0);
        wait_done(50, n);
        chk("adj_latency", n, 2);
        tick();
        go(4'd14, 4'd15, 4'd2);
        wait_done(50, n);
        chk("top_latency", n, 4);
        chk("top_final_cnt", int'(cnt), 14);
        tick();

`ifdef CONT_SEQ_HOLD_EN
        // Hold for five cycles mid-sweep
        go(4'd2, 4'd5, 4'd1);
        tick();
        hold = 1'b1;
        repeat (5) tick();
        chk("hold_cnt", int'(cnt), 3);
        chk("hold_busy", int'(busy), 1);
        hold = 1'b0;
        wait_done(50, n);
        chk("hold_latency", n + 6, 11);
        tick();
`endif

        tick();
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cont_seq
`default_nettype wire
